ph_alarm_monitor: RTL and testbench

Sequential alarm stage placed directly downstream of the blood-pH analyzer. It consumes the analyzer's per-sample `abnormalityP` / `abnormalityQ` flags and filters them with consecutive-sample counters. It drives a warning/alarm state machine with an operator acknowledge handshake, so a single out-of-range pH reading never raises an alarm by itself.

---
 rtl/ph_alarm_monitor.sv | 122 ++++++++++++
 tb/tb_ph_alarm_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ph_alarm_monitor.sv
// Debounced warning/alarm stage for the blood-pH analyzer flags.
// Consecutive-sample run counters feed a latched alarm FSM with operator acknowledge.
module ph_alarm_monitor #(
    parameter int WARN_COUNT  = 3,
    parameter int ALARM_COUNT = 4,
    parameter int CLEAR_COUNT = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sampleValid,
    input  logic       abnormalityP,
    input  logic       abnormalityQ,
    input  logic       alarmAck,
    output logic       warning,
    output logic       alarm,
    output logic [1:0] state,
    output logic [7:0] alarmCount
);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        WARN   = 2'b01,
        ALARM  = 2'b10,
        ACKED  = 2'b11
    } state_t;

    state_t stateReg;

    // A Q-only flag cannot come from the analyzer, so Q always implies P.
    logic pE, qE;
    assign pE = abnormalityP | abnormalityQ;
    assign qE = abnormalityQ;

    logic ackTake;
    assign ackTake = (stateReg == ALARM) && alarmAck;

    // Index 0: P run (WARN), 1: Q run (ALARM), 2: normal run (CLEAR).
    logic [2:0] runFlag;
    logic [2:0] runHit;
    assign runFlag = {!pE, qE, pE};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : runGen
            localparam logic [CNT_W-1:0] LIM = CNT_W'((gi == 0) ? WARN_COUNT :
                                                     (gi == 1) ? ALARM_COUNT : CLEAR_COUNT);
            logic [CNT_W-1:0] runReg;
            logic [CNT_W-1:0] runNext;

            always_comb begin
                runNext = runReg;
                if (sampleValid) begin
                    if (!runFlag[gi])
                        runNext = '0;
                    else if (runReg == LIM)
                        runNext = LIM;
                    else
                        runNext = runReg + CNT_W'(1);
                end
            end

            assign runHit[gi] = sampleValid && (runNext == LIM);

            // On acknowledge the runs restart from the concurrent sample only.
            always_ff @(posedge clk) begin
                if (rst)
                    runReg <= '0;
                else if (ackTake)
                    runReg <= CNT_W'(sampleValid && runFlag[gi]);
                else
                    runReg <= runNext;
            end
        end
    endgenerate

    logic hitP, hitQ, hitOk;
    assign hitP  = runHit[0];
    assign hitQ  = runHit[1];
    assign hitOk = runHit[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= NORMAL;
            warning    <= 1'b0;
            alarm      <= 1'b0;
            alarmCount <= 8'd0;
        end else begin
            case (stateReg)
                NORMAL, WARN, ACKED: begin
                    if (hitQ) begin
                        stateReg <= ALARM;
                        warning  <= 1'b0;
                        alarm    <= 1'b1;
                        if (alarmCount != 8'hFF)
                            alarmCount <= alarmCount + 8'd1;
                    end else if (stateReg == NORMAL) begin
                        if (hitP) begin
                            stateReg <= WARN;
                            warning  <= 1'b1;
                        end
                    end else if (hitOk) begin
                        stateReg <= NORMAL;
                        warning  <= 1'b0;
                    end
                end
                ALARM: begin
                    // Latched: only the operator can leave ALARM.
                    if (alarmAck) begin
                        stateReg <= ACKED;
                        warning  <= 1'b1;
                        alarm    <= 1'b0;
                    end
                end
                default: stateReg <= NORMAL;
            endcase
        end
    end

    assign state = stateReg;

endmodule

// File: tb/tb_ph_alarm_monitor.sv
// Bench for ph_alarm_monitor: directed test-plan sequences plus random samples,
// all checked cycle by cycle against an arithmetic reference model.
module tb_ph_alarm_monitor;

    localparam int W = 3;
    localparam int A = 4;
    localparam int C = 2;

    logic       clk;
    logic       rst;
    logic       sampleValid;
    logic       abnormalityP;
    logic       abnormalityQ;
    logic       alarmAck;
    logic       warning;
    logic       alarm;
    logic [1:0] state;
    logic [7:0] alarmCount;

    ph_alarm_monitor #(
        .WARN_COUNT (W),
        .ALARM_COUNT(A),
        .CLEAR_COUNT(C),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sampleValid (sampleValid),
        .abnormalityP(abnormalityP),
        .abnormalityQ(abnormalityQ),
        .alarmAck    (alarmAck),
        .warning     (warning),
        .alarm       (alarm),
        .state       (state),
        .alarmCount  (alarmCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: state as 0..3 (NORMAL, WARN, ALARM, ACKED), runs as plain integers.
    int mState = 0;
    int mP = 0, mQ = 0, mOk = 0;
    int mCount = 0;

    task automatic checkEq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic modelStep(input bit v, input bit p, input bit q, input bit ack, input bit r);
        bit pe, qe, hq, hp, hok;
        if (r) begin
            mState = 0; mP = 0; mQ = 0; mOk = 0; mCount = 0;
            return;
        end
        pe = p | q;
        qe = q;
        if (mState == 2 && ack) begin
            mState = 3;
            mP  = (v && pe)  ? 1 : 0;
            mQ  = (v && qe)  ? 1 : 0;
            mOk = (v && !pe) ? 1 : 0;
            return;
        end
        if (v) begin
            mP  = pe  ? minInt(mP + 1, W)  : 0;
            mQ  = qe  ? minInt(mQ + 1, A)  : 0;
            mOk = !pe ? minInt(mOk + 1, C) : 0;
        end
        hq  = v && (mQ == A);
        hp  = v && (mP == W);
        hok = v && (mOk == C);
        if (mState != 2) begin
            if (hq) begin
                mState = 2;
                mCount = minInt(mCount + 1, 255);
            end else if (mState == 0 && hp) begin
                mState = 1;
            end else if (mState != 0 && hok) begin
                mState = 0;
            end
        end
    endtask

    task automatic cycle(input bit v, input bit p, input bit q, input bit ack, input bit r);
        sampleValid  = v;
        abnormalityP = p;
        abnormalityQ = q;
        alarmAck     = ack;
        rst          = r;
        @(posedge clk);
        modelStep(v, p, q, ack, r);
        #1;
        checkEq("state",      int'(state),      mState);
        checkEq("warning",    int'(warning),    (mState == 1 || mState == 3) ? 1 : 0);
        checkEq("alarm",      int'(alarm),      (mState == 2) ? 1 : 0);
        checkEq("alarmCount", int'(alarmCount), mCount);
        $display("cyc v=%0b p=%0b q=%0b ack=%0b rst=%0b -> state=%0d warn=%0b alarm=%0b cnt=%0d",
                 v, p, q, ack, r, state, warning, alarm, alarmCount);
    endtask

    task automatic phSample(input int ph, input bit ack);
        bit p, q;
        p = !(ph == 7 || ph == 8);
        q = !(ph >= 6 && ph <= 9);
        cycle(1'b1, p, q, ack, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        sampleValid = 0; abnormalityP = 0; abnormalityQ = 0; alarmAck = 0; rst = 1;

        cycle(0, 0, 0, 0, 1);
        checkEq("reset_state", int'(state), 0);
        checkEq("reset_count", int'(alarmCount), 0);

        for (int i = 0; i < 5; i++) phSample(7, 0);
        checkEq("normal_run_state", int'(state), 0);

        for (int i = 0; i < 2; i++) phSample(6, 0);
        checkEq("pre_warn_state", int'(state), 0);
        phSample(6, 0);
        checkEq("warn_state", int'(state), 1);
        checkEq("warn_flag", int'(warning), 1);
        phSample(7, 0);
        checkEq("warn_hold", int'(state), 1);
        phSample(7, 0);
        checkEq("clear_state", int'(state), 0);

        for (int i = 0; i < 3; i++) begin
            phSample(12, 0);
            idle();
        end
        checkEq("q_warn_state", int'(state), 1);
        phSample(12, 0);
        checkEq("alarm_state", int'(state), 2);
        checkEq("alarm_flag", int'(alarm), 1);
        checkEq("alarm_count1", int'(alarmCount), 1);
        for (int i = 0; i < 10; i++) phSample(7, 0);
        checkEq("alarm_latched", int'(state), 2);

        phSample(12, 1);
        checkEq("acked_state", int'(state), 3);
        checkEq("acked_warn", int'(warning), 1);
        checkEq("acked_alarm", int'(alarm), 0);
        phSample(12, 1);
        phSample(12, 1);
        checkEq("acked_hold", int'(state), 3);
        phSample(12, 0);
        checkEq("realarm_state", int'(state), 2);
        checkEq("alarm_count2", int'(alarmCount), 2);

        cycle(0, 0, 0, 1, 0);
        checkEq("ack_idle_state", int'(state), 3);
        phSample(7, 0);
        phSample(7, 0);
        checkEq("acked_clear", int'(state), 0);

        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0);
        checkEq("illegal_warn", int'(state), 1);
        cycle(1, 0, 1, 0, 0);
        checkEq("illegal_alarm", int'(state), 2);
        checkEq("alarm_count3", int'(alarmCount), 3);

        cycle(0, 0, 0, 1, 1);
        checkEq("rst_ack_state", int'(state), 0);
        checkEq("rst_ack_count", int'(alarmCount), 0);

        for (int i = 0; i < 2000; i++) begin
            int ph;
            bit v, ack, r;
            v   = ($urandom_range(0, 3) != 0);
            ph  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(7, 8)) : int'($urandom_range(0, 14));
            ack = ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0)
                cycle(v, 0, 1, ack, r);
            else if (v) begin
                bit p, q;
                p = !(ph == 7 || ph == 8);
                q = !(ph >= 6 && ph <= 9);
                cycle(1, p, q, ack, r);
            end else
                cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ack, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
